invaes_spi: RTL and testbench

SPI-style serial front end for the inverse AES core, running on the system clock. It shifts a key and a 128-bit cyphertext in from the host, holds them stable, and drives the core's `ce` (load) input. It watches the core's `done`, captures the plaintext, and shifts it back out to the host. It sits directly between the host pins and the decryption core: upstream of the core's `key`/`cyphertext`/`ce` inputs and downstream of its `done`/`plaintext` outputs.

---
 rtl/invaes_spi.sv | 141 ++++++++++++++
 tb/tb_invaes_spi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/invaes_spi.sv
// SPI-style serial front end for the inverse AES core: shifts key+cyphertext in,
// drives ce, captures plaintext on done and shifts it back out on sdo.
module invaes_spi #(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sck,
  input  logic           sdi,
  input  logic           load,
  output logic           sdo,
  output logic           ready,
  output logic           err,
  output logic           ce,
  output logic [K-1:0]   key,
  output logic [127:0]   cyphertext,
  input  logic           done,
  input  logic [127:0]   plaintext,
  output logic [1:0]     dbg_state
);

  localparam int N  = K + 128;
  localparam int CW = $clog2(K + 129);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  // Handshake: there is no valid/ready pairing with the host; load frames a
  // transfer, sck qualifies each bit, and ready stays high while sdo carries data.
  state_t         state, state_d;
  logic [2:0]     sck_q, sdi_q, load_q, done_q;
  logic           sck_rise, sck_fall, load_rise, load_fall, done_rise;
  logic [N-1:0]   in_sr, in_sr_d;
  logic [CW-1:0]  bitcnt, bitcnt_d;
  logic           ovf, ovf_d;
  logic [127:0]   out_sr, out_sr_d;
  logic [7:0]     outcnt, outcnt_d;
  logic           err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q  <= '0;
      sdi_q  <= '0;
      load_q <= '0;
      done_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      sdi_q  <= {sdi_q[1:0], sdi};
      load_q <= {load_q[1:0], load};
      done_q <= {done_q[1:0], done};
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign load_rise = load_q[1] & ~load_q[2];
  assign load_fall = ~load_q[1] & load_q[2];
  assign done_rise = done_q[1] & ~done_q[2];

  always_comb begin
    state_d  = state;
    in_sr_d  = in_sr;
    bitcnt_d = bitcnt;
    ovf_d    = ovf;
    out_sr_d = out_sr;
    outcnt_d = outcnt;
    err_d    = err;
    if (load_rise) begin
      state_d  = LOAD;
      bitcnt_d = '0;
      outcnt_d = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // bitcnt saturates, so a separate flag remembers that extra bits arrived
          if (sck_rise) begin
            if (bitcnt == CW'(N)) begin
              ovf_d = 1'b1;
            end else begin
              in_sr_d  = {in_sr[N-2:0], sdi_q[2]};
              bitcnt_d = bitcnt + CW'(1);
            end
          end
          if (load_fall) begin
            if (bitcnt_d == CW'(N) && !ovf_d) begin
              state_d = RUN;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        RUN: begin
          if (done_rise) begin
            out_sr_d = plaintext;
            state_d  = OUT;
          end
        end
        OUT: begin
          if (sck_fall) begin
            out_sr_d = {out_sr[126:0], 1'b0};
            outcnt_d = outcnt + 8'd1;
            if (outcnt == 8'd127) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      in_sr  <= '0;
      bitcnt <= '0;
      ovf    <= 1'b0;
      out_sr <= '0;
      outcnt <= '0;
      err    <= 1'b0;
      ce     <= 1'b0;
      ready  <= 1'b0;
    end else begin
      state  <= state_d;
      in_sr  <= in_sr_d;
      bitcnt <= bitcnt_d;
      ovf    <= ovf_d;
      out_sr <= out_sr_d;
      outcnt <= outcnt_d;
      err    <= err_d;
      ce     <= (state_d == LOAD);
      ready  <= (state_d == OUT);
    end
  end

  assign sdo        = (state == OUT) & out_sr[127];
  assign key        = in_sr[N-1:128];
  assign cyphertext = in_sr[127:0];
  assign dbg_state  = state;

endmodule

// File: tb/tb_invaes_spi.sv
// Directed bench for invaes_spi (K=128): serial load, core handshake, readout,
// error windows, stale done, abort and asynchronous reset.
module tb_invaes_spi;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_OUT = 2'd3;

  logic clk = 1'b0, reset = 1'b0, sck = 1'b0, sdi = 1'b0, load = 1'b0, done = 1'b0;
  logic [127:0] plaintext = '0;
  logic sdo, ready, err, ce;
  logic [127:0] key, cyphertext;
  logic [1:0] dbg_state;

  logic [127:0] exp_q[$];
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  invaes_spi #(.K(128)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load), .sdo(sdo),
    .ready(ready), .err(err), .ce(ce), .key(key), .cyphertext(cyphertext),
    .done(done), .plaintext(plaintext), .dbg_state(dbg_state)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait; the final comparison doubles as the timeout report.
  task automatic wait_ready(input logic val, input int budget, input string tag);
    for (int i = 0; i < budget && ready !== val; i++) @(negedge clk);
    chk_bit(tag, ready, val);
  endtask

  task automatic wait_ce(input logic val, input int budget, input string tag);
    for (int i = 0; i < budget && ce !== val; i++) @(negedge clk);
    chk_bit(tag, ce, val);
  endtask

  task automatic sck_cycle(input logic b);
    sdi = b;
    wait_clks(6);
    sck = 1'b1;
    wait_clks(6);
    sck = 1'b0;
  endtask

  task automatic shift_bits(input logic [511:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sck_cycle(v[i]);
    wait_clks(6);
  endtask

  task automatic load_window(input logic [511:0] v, input int n);
    load = 1'b1;
    wait_clks(8);
    shift_bits(v, n);
    load = 1'b0;
    wait_clks(8);
  endtask

  // Host reads MSB first, sampling sdo just before each sck rising edge.
  task automatic read_bits(input int n, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[126:0], sdo};
      sck = 1'b1;
      wait_clks(6);
      sck = 1'b0;
      wait_clks(6);
    end
  endtask

  task automatic core_done(input logic [127:0] pt);
    plaintext = pt;
    wait_clks(2);
    done = 1'b1;
  endtask

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [127:0] k1, c1, pt, got, exp_pt;
  logic [255:0] old_in, exp_in;
  logic [511:0] rv;

  initial begin
    // reset state
    wait_clks(3);
    chk_st("rst_state", dbg_state, S_IDLE);
    chk_bit("rst_ce", ce, 1'b0);
    chk_bit("rst_ready", ready, 1'b0);
    chk_bit("rst_err", err, 1'b0);
    chk_bit("rst_sdo", sdo, 1'b0);
    chk_vec("rst_key_ct", {key, cyphertext}, 256'd0);
    reset = 1'b1;
    wait_clks(4);

    // nominal decrypt
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    chk_bit("idle_ce", ce, 1'b0);
    load = 1'b1;
    wait_ce(1'b1, 10, "nom_ce_rise");
    chk_st("nom_state_load", dbg_state, S_LOAD);
    shift_bits({256'd0, k1, c1}, 256);
    chk_bit("nom_ce_during", ce, 1'b1);
    load = 1'b0;
    wait_ce(1'b0, 10, "nom_ce_fall");
    chk_st("nom_state_run", dbg_state, S_RUN);
    chk_vec("nom_key_ct", {key, cyphertext}, {k1, c1});
    chk_bit("nom_err", err, 1'b0);
    pt = 128'h00112233445566778899aabbccddeeff;
    exp_q.push_back(pt);
    core_done(pt);
    wait_ready(1'b1, 10, "nom_ready");
    chk_st("nom_state_out", dbg_state, S_OUT);
    read_bits(128, got);
    exp_pt = exp_q.pop_front();
    chk_vec("nom_plaintext", {128'd0, got}, {128'd0, exp_pt});
    chk_bit("nom_ready_end", ready, 1'b0);
    chk_st("nom_state_end", dbg_state, S_IDLE);
    done = 1'b0;
    wait_clks(6);

    // short load: 200 bits, partial contents kept, core not started
    old_in = {key, cyphertext};
    rv = rand_vec();
    load_window(rv, 200);
    exp_in = (old_in << 200) | {56'd0, rv[199:0]};
    chk_bit("short_err", err, 1'b1);
    chk_bit("short_ce", ce, 1'b0);
    chk_st("short_state", dbg_state, S_IDLE);
    chk_vec("short_in_sr", {key, cyphertext}, exp_in);
    core_done(128'hdeadbeef);
    wait_clks(10);
    chk_bit("short_no_ready", ready, 1'b0);
    chk_st("short_no_capture", dbg_state, S_IDLE);
    done = 1'b0;
    wait_clks(6);

    // overlong load: 300 bits, first 256 kept
    rv = rand_vec();
    load_window(rv, 300);
    chk_bit("long_err", err, 1'b1);
    chk_st("long_state", dbg_state, S_IDLE);
    chk_vec("long_in_sr", {key, cyphertext}, rv[299:44]);

    // correct load clears err; done already high on RUN entry is ignored
    rv = rand_vec();
    load = 1'b1;
    wait_ce(1'b1, 10, "stale_ce_rise");
    chk_bit("stale_err_clear", err, 1'b0);
    core_done(128'h1111);
    shift_bits(rv, 256);
    load = 1'b0;
    wait_clks(8);
    chk_bit("stale_err", err, 1'b0);
    chk_vec("stale_key_ct", {key, cyphertext}, rv[255:0]);
    wait_clks(20);
    chk_st("stale_still_run", dbg_state, S_RUN);
    chk_bit("stale_no_ready", ready, 1'b0);
    done = 1'b0;
    wait_clks(8);
    pt = rv[511:384];
    exp_q.push_back(pt);
    core_done(pt);
    wait_ready(1'b1, 10, "stale_ready");
    read_bits(128, got);
    exp_pt = exp_q.pop_front();
    chk_vec("stale_plaintext", {128'd0, got}, {128'd0, exp_pt});
    done = 1'b0;
    wait_clks(6);

    // abort after 40 output bits, then a fresh cycle
    rv = rand_vec();
    load_window(rv, 256);
    pt = rv[383:256];
    core_done(pt);
    wait_ready(1'b1, 10, "abort_ready");
    read_bits(40, got);
    chk_vec("abort_prefix", {216'd0, got[39:0]}, {216'd0, pt[127:88]});
    done = 1'b0;
    load = 1'b1;
    wait_ready(1'b0, 6, "abort_ready_drop");
    wait_ce(1'b1, 4, "abort_ce");
    chk_st("abort_state_load", dbg_state, S_LOAD);
    rv = rand_vec();
    shift_bits(rv, 256);
    load = 1'b0;
    wait_clks(8);
    chk_vec("abort_key_ct", {key, cyphertext}, rv[255:0]);
    pt = rv[511:384];
    exp_q.push_back(pt);
    core_done(pt);
    wait_ready(1'b1, 10, "abort2_ready");
    read_bits(128, got);
    exp_pt = exp_q.pop_front();
    chk_vec("abort2_plaintext", {128'd0, got}, {128'd0, exp_pt});
    chk_st("abort2_state_end", dbg_state, S_IDLE);
    done = 1'b0;
    wait_clks(6);

    // asynchronous reset in RUN, checked before any clk edge
    rv = rand_vec();
    load_window(rv, 256);
    chk_st("rrun_state", dbg_state, S_RUN);
    #2 reset = 1'b0;
    #1;
    chk_st("rrun_state_rst", dbg_state, S_IDLE);
    chk_bit("rrun_ce", ce, 1'b0);
    chk_bit("rrun_ready", ready, 1'b0);
    chk_bit("rrun_err", err, 1'b0);
    chk_bit("rrun_sdo", sdo, 1'b0);
    chk_vec("rrun_key_ct", {key, cyphertext}, 256'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_clks(4);
    chk_bit("queue_empty", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
